// File: rtl/servo_pos_ctrl.sv
// servo_pos_ctrl: five-joint saturating position engine stepped by a tick divider.
// Optional hobby-servo PWM outputs are built only when SERVO_PWM_EN is defined.
module servo_pos_ctrl #(
  parameter int unsigned STEP_DIV   = 500000,
  parameter logic [7:0]  POS_INIT   = 8'h80,
  parameter logic [7:0]  POS_MIN    = 8'h00,
  parameter logic [7:0]  POS_MAX    = 8'hFF,
  parameter int unsigned PWM_PERIOD = 1000000,
  parameter int unsigned PWM_MIN    = 50000,
  parameter int unsigned PWM_LSB    = 196
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] btn1,
  input  logic [1:0] btn2,
  input  logic [1:0] btn3,
  input  logic [1:0] btn4,
  input  logic [1:0] btn5,
  output logic [7:0] pos1,
  output logic [7:0] pos2,
  output logic [7:0] pos3,
  output logic [7:0] pos4,
  output logic [7:0] pos5,
  output logic [4:0] moving,
  output logic       step_tick,
  output logic [4:0] pwm
);
  logic [31:0] r_step;
  logic [7:0]  r_pos [5];
  logic [1:0]  w_btn [5];
  logic [4:0]  w_inc, w_dec, r_moving;
  assign w_btn[0] = btn1;
  assign w_btn[1] = btn2;
  assign w_btn[2] = btn3;
  assign w_btn[3] = btn4;
  assign w_btn[4] = btn5;
  assign pos1 = r_pos[0];
  assign pos2 = r_pos[1];
  assign pos3 = r_pos[2];
  assign pos4 = r_pos[3];
  assign pos5 = r_pos[4];
  assign moving = r_moving;
  assign step_tick = r_step == STEP_DIV - 1;
  // strict limit compares also keep 8-bit arithmetic from wrapping at 0x00/0xFF
  for (genvar i = 0; i < 5; i++) begin : g_cmd
    assign w_inc[i] = w_btn[i] == 2'b01 && r_pos[i] < POS_MAX;
    assign w_dec[i] = w_btn[i] == 2'b10 && r_pos[i] > POS_MIN;
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_step   <= '0;
      r_moving <= '0;
      for (int i = 0; i < 5; i++) r_pos[i] <= POS_INIT;
    end else begin
      r_step <= step_tick ? '0 : r_step + 32'd1;
      if (step_tick) begin
        r_moving <= w_inc | w_dec;
        for (int i = 0; i < 5; i++)
          r_pos[i] <= w_inc[i] ? r_pos[i] + 8'd1 : w_dec[i] ? r_pos[i] - 8'd1 : r_pos[i];
      end
    end
`ifdef SERVO_PWM_EN
  logic [31:0] r_frm;
  logic [7:0]  r_shadow [5];
  logic [7:0]  w_src [5];
  logic [4:0]  r_pwm;
  // at count 0 the shadow is being loaded, so compare against the value it takes
  for (genvar i = 0; i < 5; i++) begin : g_src
    assign w_src[i] = r_frm == 0 ? r_pos[i] : r_shadow[i];
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_frm <= '0;
      r_pwm <= '0;
      for (int i = 0; i < 5; i++) r_shadow[i] <= POS_INIT;
    end else begin
      r_frm <= r_frm == PWM_PERIOD - 1 ? '0 : r_frm + 32'd1;
      for (int i = 0; i < 5; i++) begin
        if (r_frm == 0) r_shadow[i] <= r_pos[i];
        r_pwm[i] <= r_frm < PWM_MIN + 32'(w_src[i]) * PWM_LSB;
      end
    end
  assign pwm = r_pwm;
`else
  assign pwm = '0;
`endif
endmodule

// File: tb/tb_servo_pos_ctrl.sv
// tb_servo_pos_ctrl: vector table plus scoreboard of per-tick expectations for servo_pos_ctrl.
module tb_servo_pos_ctrl;
  logic clk = 0, rst = 1;
  logic [1:0] btn1 = 0, btn2 = 0, btn3 = 0, btn4 = 0, btn5 = 0, sb4 = 0;
  logic [7:0] pos1, pos2, pos3, pos4, pos5, sp1, sp2, sp3, sp4, sp5;
  logic [4:0] moving, pwm, smov, spwm;
  logic step_tick, stick;
  int n_vec = 0, n_err = 0;

  typedef struct packed { logic [9:0] b; logic [39:0] p; logic [4:0] mv; } vec_t;
  typedef struct packed { logic [39:0] p; logic [4:0] mv; logic [7:0] sp; logic smv; } exp_t;
  exp_t q[$];
  vec_t tbl[7];
  logic [7:0] mp[5];
  logic [7:0] msp;

  always #5 clk = ~clk;

  servo_pos_ctrl #(.STEP_DIV(4), .PWM_PERIOD(400), .PWM_MIN(20), .PWM_LSB(1)) dut (
    .clk(clk), .rst(rst), .btn1(btn1), .btn2(btn2), .btn3(btn3), .btn4(btn4), .btn5(btn5),
    .pos1(pos1), .pos2(pos2), .pos3(pos3), .pos4(pos4), .pos5(pos5),
    .moving(moving), .step_tick(step_tick), .pwm(pwm));

  servo_pos_ctrl #(.STEP_DIV(4), .POS_MAX(8'h82), .PWM_PERIOD(400), .PWM_MIN(20), .PWM_LSB(1)) u_sat (
    .clk(clk), .rst(rst), .btn1(2'b00), .btn2(2'b00), .btn3(2'b00), .btn4(sb4), .btn5(2'b00),
    .pos1(sp1), .pos2(sp2), .pos3(sp3), .pos4(sp4), .pos5(sp5),
    .moving(smov), .step_tick(stick), .pwm(spwm));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] nextp(input logic [7:0] p, input logic [1:0] b, input logic [7:0] mx);
    return (b == 2'b01 && p < mx) ? p + 8'd1 : (b == 2'b10 && p > 8'h00) ? p - 8'd1 : p;
  endfunction

  task automatic run_tick(input logic [9:0] b, input logic [1:0] sb, input exp_t e);
    exp_t g;
    int n = 0;
    @(negedge clk);
    {btn5, btn4, btn3, btn2, btn1} = b;
    sb4 = sb;
    q.push_back(e);
    while (step_tick !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("tick_wait", {63'd0, step_tick}, 64'd1);
    @(posedge clk);
    #1;
    g = q.pop_front();
    check("pos", {24'd0, pos5, pos4, pos3, pos2, pos1}, {24'd0, g.p});
    check("moving", {59'd0, moving}, {59'd0, g.mv});
    check("sat_pos4", {56'd0, sp4}, {56'd0, g.sp});
    check("sat_mov3", {63'd0, smov[3]}, {63'd0, g.smv});
  endtask

  task automatic step_model(input logic [9:0] b, input logic [1:0] sb);
    exp_t e;
    logic [7:0] np;
    for (int i = 0; i < 5; i++) begin
      np = nextp(mp[i], b[2*i+:2], 8'hFF);
      e.mv[i] = np != mp[i];
      mp[i] = np;
      e.p[8*i+:8] = np;
    end
    np = nextp(msp, sb, 8'h82);
    e.smv = np != msp;
    msp = np;
    e.sp = np;
    run_tick(b, sb, e);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int h1, h2, h3, h0;
    tbl[0] = '{10'b00_00_00_00_00, 40'h80_80_80_80_80, 5'b00000};
    tbl[1] = '{10'b00_00_00_11_01, 40'h80_80_80_80_81, 5'b00001};
    tbl[2] = '{10'b00_00_00_11_01, 40'h80_80_80_80_82, 5'b00001};
    tbl[3] = '{10'b00_00_00_11_01, 40'h80_80_80_80_83, 5'b00001};
    tbl[4] = '{10'b00_00_01_10_10, 40'h80_80_81_7F_82, 5'b00111};
    tbl[5] = '{10'b10_00_00_00_00, 40'h7F_80_81_7F_82, 5'b10000};
    tbl[6] = '{10'b00_01_00_00_00, 40'h7F_81_81_7F_82, 5'b01000};
    repeat (3) @(posedge clk);
    #1 rst = 0;
    check("rst_pos", {24'd0, pos5, pos4, pos3, pos2, pos1}, {24'd0, 40'h80_80_80_80_80});
    check("rst_moving", {59'd0, moving}, 64'd0);
    check("rst_pwm", {59'd0, pwm}, 64'd0);
    for (int k = 0; k < 12; k++) begin
      check("tick_phase", {63'd0, step_tick}, {63'd0, k % 4 == 3});
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 7; i++) run_tick(tbl[i].b, 2'b00, {tbl[i].p, tbl[i].mv, 8'h80, 1'b0});
    for (int i = 0; i < 5; i++) mp[i] = tbl[6].p[8*i+:8];
    msp = 8'h80;
    @(negedge clk);
    btn1 = 2'b01;
    @(negedge clk);
    btn1 = 2'b00;
    step_model(10'd0, 2'b00);
    repeat (5) step_model(10'd0, 2'b01);
    for (int t = 0; t < 131; t++) step_model({2'b10, 6'd0, mp[0] < 8'h90 ? 2'b01 : 2'b00}, 2'b00);
    check("pos5_floor", {56'd0, pos5}, 64'h00);
    check("pos1_pre_rst", {56'd0, pos1}, 64'h90);
    repeat (37) @(negedge clk);
    btn1 = 0; btn5 = 0; sb4 = 0;
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    check("mid_rst_pos1", {56'd0, pos1}, 64'h80);
    check("mid_rst_pwm", {59'd0, pwm}, 64'd0);
    check("mid_rst_moving", {59'd0, moving}, 64'd0);
    check("mid_rst_tick", {63'd0, step_tick}, 64'd0);
    h0 = 0; h1 = 0; h2 = 0; h3 = 0;
    for (int k = 1; k <= 1200; k++) begin
      @(posedge clk);
      #1;
`ifdef SERVO_PWM_EN
      if (k == 1) check("pwm_rise", {59'd0, pwm}, 64'h1F);
`else
      if (k == 1) check("pwm_rise", {59'd0, pwm}, 64'h00);
`endif
      if (k == 2) check("tick_restart_lo", {63'd0, step_tick}, 64'd0);
      if (k == 3) check("tick_restart_hi", {63'd0, step_tick}, 64'd1);
      if (k <= 400) begin h1 += int'(pwm[4]); h0 += int'(pwm[0]); end
      else if (k <= 800) h2 += int'(pwm[4]);
      else h3 += int'(pwm[4]);
      btn5 = (k >= 600 && k < 640) ? 2'b01 : 2'b00;
    end
    check("pos5_after_bump", {56'd0, pos5}, 64'h8A);
`ifdef SERVO_PWM_EN
    check("pwm0_width", 64'(h0), 64'd148);
    check("pwm4_width_f1", 64'(h1), 64'd148);
    check("pwm4_width_f2", 64'(h2), 64'd148);
    check("pwm4_width_f3", 64'(h3), 64'd158);
`else
    check("pwm0_off", 64'(h0), 64'd0);
    check("pwm4_off_f1", 64'(h1), 64'd0);
    check("pwm4_off_f2", 64'(h2), 64'd0);
    check("pwm4_off_f3", 64'(h3), 64'd0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
